// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO pin bank.
//   - 6-bit byte addresses of the register map
//   - register reset value
//   - per-pin interrupt mode encodings (INT_TYPE / INT_POLARITY bits)
package gpio_pkg;

  localparam int ADDR_W = 6;

  localparam logic [ADDR_W-1:0] ADDR_DIRECTION     = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_OUTPUT_ENABLE = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_OUTPUT_VALUE  = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_INPUT_VALUE   = 6'h10;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET       = 6'h14;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR       = 6'h18;
  localparam logic [ADDR_W-1:0] ADDR_INT_ENABLE    = 6'h1C;
  localparam logic [ADDR_W-1:0] ADDR_INT_STATUS    = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_INT_TYPE      = 6'h24;
  localparam logic [ADDR_W-1:0] ADDR_INT_POLARITY  = 6'h28;
  localparam logic [ADDR_W-1:0] ADDR_INT_ANY_EDGE  = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_FILTER_ENABLE = 6'h30;

  // Every register and flop in the bank clears to zero; sliced to WIDTH at use.
  localparam logic [31:0] RESET_VALUE = 32'h0;

  localparam logic INT_TYPE_EDGE     = 1'b0;
  localparam logic INT_TYPE_LEVEL    = 1'b1;
  localparam logic INT_POL_RISE_HIGH = 1'b0;  // edge: rising, level: high
  localparam logic INT_POL_FALL_LOW  = 1'b1;  // edge: falling, level: low

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input path of the pin bank.
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   pin_i          asynchronous pin inputs
//   filter_en_i    per-pin glitch filter enable
//   value_o        filtered, synchronised pin state (INPUT_VALUE)
//   rise_o/fall_o  raw edges: next INPUT_VALUE differs from the current one
module gpio_in_filter #(
  parameter int WIDTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] filter_en_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  import gpio_pkg::*;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q [FILTER_DEPTH-1];
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] sync_last, all_one, all_zero;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE[WIDTH-1:0];
      for (int h = 0; h < FILTER_DEPTH-1; h++) hist_q[h] <= RESET_VALUE[WIDTH-1:0];
      value_q <= RESET_VALUE[WIDTH-1:0];
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      // History shifts unconditionally so enabling the filter needs no refill.
      hist_q[0] <= sync_last;
      for (int h = 1; h < FILTER_DEPTH-1; h++) hist_q[h] <= hist_q[h-1];
      value_q <= value_d;
    end
  end

  always_comb begin
    all_one  = sync_last;
    all_zero = ~sync_last;
    for (int h = 0; h < FILTER_DEPTH-1; h++) begin
      all_one  = all_one & hist_q[h];
      all_zero = all_zero & ~hist_q[h];
    end
    // Uniform window passes its value; a mixed window holds the current state.
    value_d = (filter_en_i & (all_one | (value_q & ~all_zero)))
            | (~filter_en_i & sync_last);
  end

  assign value_o = value_q;
  assign rise_o  = value_d & ~value_q;
  assign fall_o  = ~value_d & value_q;

endmodule

// File: rtl/gpio_param_subunit.sv
// gpio_param_subunit: parametrised GPIO pin bank behind the APB decode.
//   pclk, n_reset       clock and asynchronous active-low reset
//   read, write, addr   single-cycle register strobes, word-aligned byte address
//   wdata / rdata       write data / registered read data (1-cycle latency)
//   pin_in              asynchronous pin inputs
//   tri_state_enable    DFT force of pin_oe_n high
//   pin_out, pin_oe_n   pin drive value and active-low output enable
//   interrupt, irq      per-pin masked status and its OR
module gpio_param_subunit
  import gpio_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_DEPTH = 3
) (
  input  logic              pclk,
  input  logic              n_reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  pin_in,
  input  logic [WIDTH-1:0]  tri_state_enable,
  output logic [WIDTH-1:0]  rdata,
  output logic [WIDTH-1:0]  pin_out,
  output logic [WIDTH-1:0]  pin_oe_n,
  output logic [WIDTH-1:0]  interrupt,
  output logic              irq
);

  logic [WIDTH-1:0] dir_q, dir_d, oe_q, oe_d, out_q, out_d, ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d, type_q, type_d, pol_q, pol_d;
  logic [WIDTH-1:0] any_q, any_d, fen_q, fen_d, rdata_q, rdata_d;
  logic [WIDTH-1:0] in_val, in_rise, in_fall, evt, trigger, w1c;

  gpio_in_filter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_DEPTH(FILTER_DEPTH)
  ) u_in_filter (
    .clk_i      (pclk),
    .rst_ni     (n_reset),
    .pin_i      (pin_in),
    .filter_en_i(fen_q),
    .value_o    (in_val),
    .rise_o     (in_rise),
    .fall_o     (in_fall)
  );

  always_comb begin
    evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (type_q[i] == INT_TYPE_EDGE) begin
        if (any_q[i])                           evt[i] = in_rise[i] | in_fall[i];
        else if (pol_q[i] == INT_POL_RISE_HIGH) evt[i] = in_rise[i];
        else                                    evt[i] = in_fall[i];
      end else begin
        evt[i] = (pol_q[i] == INT_POL_FALL_LOW) ? ~in_val[i] : in_val[i];
      end
    end
  end

  // Output pins never raise interrupts.
  assign trigger = evt & dir_q;
  assign w1c     = (write && (addr == ADDR_INT_STATUS)) ? wdata : '0;

  always_comb begin
    dir_d  = dir_q;
    oe_d   = oe_q;
    out_d  = out_q;
    ien_d  = ien_q;
    type_d = type_q;
    pol_d  = pol_q;
    any_d  = any_q;
    fen_d  = fen_q;
    if (write) begin
      case (addr)
        ADDR_DIRECTION:     dir_d  = wdata;
        ADDR_OUTPUT_ENABLE: oe_d   = wdata;
        ADDR_OUTPUT_VALUE:  out_d  = wdata;
        ADDR_OUT_SET:       out_d  = out_q | wdata;
        ADDR_OUT_CLR:       out_d  = out_q & ~wdata;
        ADDR_INT_ENABLE:    ien_d  = wdata;
        ADDR_INT_TYPE:      type_d = wdata;
        ADDR_INT_POLARITY:  pol_d  = wdata;
        ADDR_INT_ANY_EDGE:  any_d  = wdata;
        ADDR_FILTER_ENABLE: fen_d  = wdata;
        default: ;
      endcase
    end
    // Set beats a simultaneous clear, so a persisting level re-asserts.
    stat_d = (stat_q & ~w1c) | trigger;
  end

  always_comb begin
    rdata_d = '0;
    if (read) begin
      case (addr)
        ADDR_DIRECTION:     rdata_d = dir_q;
        ADDR_OUTPUT_ENABLE: rdata_d = oe_q;
        ADDR_OUTPUT_VALUE:  rdata_d = out_q;
        ADDR_INPUT_VALUE:   rdata_d = in_val;
        ADDR_INT_ENABLE:    rdata_d = ien_q;
        ADDR_INT_STATUS:    rdata_d = stat_q;
        ADDR_INT_TYPE:      rdata_d = type_q;
        ADDR_INT_POLARITY:  rdata_d = pol_q;
        ADDR_INT_ANY_EDGE:  rdata_d = any_q;
        ADDR_FILTER_ENABLE: rdata_d = fen_q;
        default:            rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge n_reset) begin
    if (!n_reset) begin
      dir_q   <= RESET_VALUE[WIDTH-1:0];
      oe_q    <= RESET_VALUE[WIDTH-1:0];
      out_q   <= RESET_VALUE[WIDTH-1:0];
      ien_q   <= RESET_VALUE[WIDTH-1:0];
      stat_q  <= RESET_VALUE[WIDTH-1:0];
      type_q  <= RESET_VALUE[WIDTH-1:0];
      pol_q   <= RESET_VALUE[WIDTH-1:0];
      any_q   <= RESET_VALUE[WIDTH-1:0];
      fen_q   <= RESET_VALUE[WIDTH-1:0];
      rdata_q <= RESET_VALUE[WIDTH-1:0];
    end else begin
      dir_q   <= dir_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      type_q  <= type_d;
      pol_q   <= pol_d;
      any_q   <= any_d;
      fen_q   <= fen_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign pin_out   = out_q;
  assign pin_oe_n  = ~(oe_q & ~dir_q) | tri_state_enable;
  assign interrupt = stat_q & ien_q;
  assign irq       = |interrupt;

endmodule
